hawk_cmpdcmp_rd_mngr: RTL and testbench

Read-side manager for the compress/decompress path in the HACD chipset block. On a trigger it reads the 64-byte zsPage metadata line at the given iWay pointer, returns the decoded metadata and next-way pointer, then streams a programmable number of compressed-page cachelines from the compressed page start address to the decompressor. It sits between the decompressor control logic and the internal AXI read engine, and is the counterpart of the compress-side write manager.

---
 rtl/hawk_cmpdcmp_rd_mngr.sv | 162 ++++++++++++++++
 tb/tb_hawk_cmpdcmp_rd_mngr.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hawk_cmpdcmp_rd_mngr.sv
// Purpose: decompress-side read manager; fetches the zsPage metadata line, then streams N compressed lines.
// Latency: trigger->first request 1 cycle; response->zspg_valid/cline_valid 1 cycle; last line->done 1 cycle.
// Backpressure: one read outstanding; next line is not requested until the one-entry line buffer drains.
// Build option: define HAWK_RD_MD_CHECK_EN to compare the embedded metadata pointer against iway_ptr.
module hawk_cmpdcmp_rd_mngr #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmpdcmp_trigger,
    input  logic [47:0]       iway_ptr,
    input  logic [ADDR_W-1:0] cpage_byte_start,
    input  logic [6:0]        cpage_nlines,
    output logic              rd_req_valid,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_req_ready,
    input  logic              rd_resp_valid,
    input  logic [DATA_W-1:0] rd_resp_data,
    output logic              rd_resp_ready,
    output logic              zspg_valid,
    output logic [399:0]      zspg_md,
    output logic [47:0]       nxtway_ptr,
    output logic              md_mismatch,
    output logic              cline_valid,
    output logic [DATA_W-1:0] cline_data,
    output logic              cline_last,
    input  logic              cline_ready,
    output logic              cmpdcmp_done
);

    typedef enum logic [2:0] {
        IDLE, ZS_REQ, ZS_RESP, CP_REQ, CP_RESP, CP_DRAIN, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [47:0]        iway_q;
    logic [ADDR_W-1:6]  cpage_q;
    logic [6:0]         nlines_q;
    logic [6:0]         cnt_q;
    logic [ADDR_W-1:0]  cp_addr;
    logic               start;
    logic               zs_take;
    logic               cp_take;
    logic               cline_take;

    assign start      = (state_q == IDLE) && cmpdcmp_trigger;
    assign zs_take    = (state_q == ZS_RESP) && rd_resp_valid;
    assign cp_take    = (state_q == CP_RESP) && rd_resp_valid && rd_resp_ready;
    assign cline_take = cline_valid && cline_ready;

    // Line address: aligned page base plus 64 bytes per line already fetched; wraps silently.
    assign cp_addr = {cpage_q, 6'b0} + ({{(ADDR_W-7){1'b0}}, cnt_q} << 6);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state decode; a single read is outstanding at any time.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (cmpdcmp_trigger) state_d = ZS_REQ;
            ZS_REQ:   if (rd_req_ready) state_d = ZS_RESP;
            ZS_RESP:  if (rd_resp_valid) state_d = (nlines_q != 7'd0) ? CP_REQ : DONE;
            CP_REQ:   if (rd_req_ready) state_d = CP_RESP;
            CP_RESP:  if (cp_take) state_d = CP_DRAIN;
            CP_DRAIN: if (cline_take) state_d = (cnt_q < nlines_q) ? CP_REQ : DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Request/response handshake outputs decoded from the registered state.
    always_comb begin
        rd_req_valid  = 1'b0;
        rd_req_addr   = '0;
        rd_resp_ready = 1'b0;
        cmpdcmp_done  = 1'b0;
        case (state_q)
            ZS_REQ: begin
                rd_req_valid = 1'b1;
                rd_req_addr  = {{(ADDR_W-48){1'b0}}, iway_q};
            end
            CP_REQ: begin
                rd_req_valid = 1'b1;
                rd_req_addr  = cp_addr;
            end
            ZS_RESP: rd_resp_ready = 1'b1;
            CP_RESP: rd_resp_ready = !cline_valid;
            DONE:    cmpdcmp_done  = 1'b1;
            default: ;
        endcase
    end

    // Operation parameters are latched on trigger; oversize line counts clamp to a full page.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            iway_q   <= '0;
            cpage_q  <= '0;
            nlines_q <= '0;
        end else if (start) begin
            iway_q   <= iway_ptr;
            cpage_q  <= cpage_byte_start[ADDR_W-1:6];
            nlines_q <= (cpage_nlines > 7'd64) ? 7'd64 : cpage_nlines;
        end
    end

    // Metadata capture; zspg_md/nxtway_ptr hold until the next metadata response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            zspg_valid <= 1'b0;
            zspg_md    <= '0;
            nxtway_ptr <= '0;
        end else begin
            zspg_valid <= zs_take;
            if (zs_take) begin
                zspg_md    <= rd_resp_data[399:0];
                nxtway_ptr <= rd_resp_data[447:400];
            end
        end
    end

    // One-entry output buffer and line counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cline_valid <= 1'b0;
            cline_data  <= '0;
            cline_last  <= 1'b0;
            cnt_q       <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (cp_take) begin
            cline_valid <= 1'b1;
            cline_data  <= rd_resp_data;
            cline_last  <= (cnt_q == nlines_q - 7'd1);
            cnt_q       <= cnt_q + 7'd1;
        end else if (cline_take) begin
            cline_valid <= 1'b0;
            cline_last  <= 1'b0;
        end
    end

`ifdef HAWK_RD_MD_CHECK_EN
    logic unused_ok;
    assign unused_ok = ^{rd_resp_data[DATA_W-1:496], cpage_byte_start[5:0]};

    // Sticky per operation: cleared on trigger, set when the embedded pointer disagrees.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      md_mismatch <= 1'b0;
        else if (start)   md_mismatch <= 1'b0;
        else if (zs_take) md_mismatch <= (rd_resp_data[495:448] != iway_q);
    end
`else
    logic unused_ok;
    assign unused_ok   = ^{rd_resp_data[DATA_W-1:448], cpage_byte_start[5:0]};
    assign md_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_hawk_cmpdcmp_rd_mngr.sv
// Directed bench for hawk_cmpdcmp_rd_mngr: a scripted read engine and decompressor
// drive each scenario; expected addresses and data are computed from the stimulus.
// Inputs and sampling both happen on the falling clock edge.
module tb_hawk_cmpdcmp_rd_mngr;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          cmpdcmp_trigger = 1'b0;
    logic [47:0]   iway_ptr = '0;
    logic [63:0]   cpage_byte_start = '0;
    logic [6:0]    cpage_nlines = '0;
    logic          rd_req_valid;
    logic [63:0]   rd_req_addr;
    logic          rd_req_ready = 1'b0;
    logic          rd_resp_valid = 1'b0;
    logic [511:0]  rd_resp_data = '0;
    logic          rd_resp_ready;
    logic          zspg_valid;
    logic [399:0]  zspg_md;
    logic [47:0]   nxtway_ptr;
    logic          md_mismatch;
    logic          cline_valid;
    logic [511:0]  cline_data;
    logic          cline_last;
    logic          cline_ready = 1'b0;
    logic          cmpdcmp_done;

    int total = 0;
    int bad   = 0;

    hawk_cmpdcmp_rd_mngr #(.ADDR_W(64), .DATA_W(512)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmpdcmp_trigger(cmpdcmp_trigger), .iway_ptr(iway_ptr),
        .cpage_byte_start(cpage_byte_start), .cpage_nlines(cpage_nlines),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .rd_resp_ready(rd_resp_ready),
        .zspg_valid(zspg_valid), .zspg_md(zspg_md), .nxtway_ptr(nxtway_ptr),
        .md_mismatch(md_mismatch),
        .cline_valid(cline_valid), .cline_data(cline_data), .cline_last(cline_last),
        .cline_ready(cline_ready), .cmpdcmp_done(cmpdcmp_done)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    function automatic logic [511:0] line_pat(input int i);
        logic [63:0] w;
        w = 64'hC0DE_0000_0000_0000 + 64'(i);
        return {8{w}};
    endfunction

    // Read engine: accept the next request (bounded wait) and report its address.
    task automatic serve_req(output logic [63:0] addr, output bit ok);
        int n = 0;
        ok = 1'b0;
        addr = '0;
        while (rd_req_valid !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (rd_req_valid === 1'b1) begin
            ok = 1'b1;
            addr = rd_req_addr;
            rd_req_ready = 1'b1;
            @(negedge clk_i);
            rd_req_ready = 1'b0;
        end
    endtask

    // Read engine: return one beat of data once the manager is ready (bounded wait).
    task automatic give_resp(input logic [511:0] d, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (rd_resp_ready !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (rd_resp_ready === 1'b1) begin
            ok = 1'b1;
            rd_resp_valid = 1'b1;
            rd_resp_data = d;
            @(negedge clk_i);
            rd_resp_valid = 1'b0;
            rd_resp_data = '0;
        end
    endtask

    // Full operation with inline checks of every request, metadata, line and done pulse.
    task automatic run_op(input string tag, input logic [47:0] iway, input logic [63:0] cpage,
                          input logic [6:0] nl, input logic [47:0] emb, input int stall);
        logic [63:0]  a, exp_a;
        logic [511:0] d;
        logic [47:0]  nxt;
        logic [399:0] md;
        logic         exp_mm, exp_last;
        bit           ok, stable;
        int           eff;
        eff = (nl > 7'd64) ? 64 : int'(nl);
        nxt = iway + 48'h1000;
        md  = {25{iway[15:0] ^ 16'hA5A5}};
`ifdef HAWK_RD_MD_CHECK_EN
        exp_mm = (emb !== iway);
`else
        exp_mm = 1'b0;
`endif
        cmpdcmp_trigger = 1'b1;
        iway_ptr = iway;
        cpage_byte_start = cpage;
        cpage_nlines = nl;
        @(negedge clk_i);
        cmpdcmp_trigger = 1'b0;
        iway_ptr = ~iway;
        cpage_byte_start = ~cpage;
        cpage_nlines = 7'd5;
        total++;
        if (rd_req_valid !== 1'b1) begin
            bad++; $display("FAIL %s_trig_lat: rd_req_valid=%b want 1", tag, rd_req_valid);
        end
        total++;
        if (md_mismatch !== 1'b0) begin
            bad++; $display("FAIL %s_mm_clear: md_mismatch=%b want 0", tag, md_mismatch);
        end
        serve_req(a, ok);
        total++;
        if (!ok || a !== {16'h0, iway}) begin
            bad++; $display("FAIL %s_zs_addr: ok=%0d addr=%h want %h", tag, ok, a, {16'h0, iway});
        end
        give_resp({16'h0, emb, nxt, md}, ok);
        total++;
        if (!ok || zspg_valid !== 1'b1 || nxtway_ptr !== nxt || zspg_md !== md) begin
            bad++; $display("FAIL %s_zspg: ok=%0d vld=%b nxt=%h want vld=1 nxt=%h md_ok=%0d",
                            tag, ok, zspg_valid, nxtway_ptr, nxt, zspg_md === md);
        end
        total++;
        if (md_mismatch !== exp_mm) begin
            bad++; $display("FAIL %s_mm: md_mismatch=%b want %b", tag, md_mismatch, exp_mm);
        end
        if (eff == 0) begin
            total++;
            if (cmpdcmp_done !== 1'b1 || rd_req_valid !== 1'b0 || cline_valid !== 1'b0) begin
                bad++; $display("FAIL %s_zero_done: done=%b req=%b cline=%b want 1 0 0",
                                tag, cmpdcmp_done, rd_req_valid, cline_valid);
            end
        end
        for (int i = 0; i < eff; i++) begin
            exp_a = {cpage[63:6], 6'b0} + 64'(i) * 64'd64;
            exp_last = (i == eff - 1);
            serve_req(a, ok);
            total++;
            if (!ok || a !== exp_a) begin
                bad++; $display("FAIL %s_cp_addr%0d: ok=%0d addr=%h want %h", tag, i, ok, a, exp_a);
            end
            d = line_pat(i);
            give_resp(d, ok);
            total++;
            if (!ok || cline_valid !== 1'b1 || cline_data !== d || cline_last !== exp_last) begin
                bad++; $display("FAIL %s_line%0d: vld=%b last=%b data=%h want vld=1 last=%b data=%h",
                                tag, i, cline_valid, cline_last, cline_data, exp_last, d);
            end
            if (stall > 0) begin
                stable = 1'b1;
                cmpdcmp_trigger = 1'b1;
                repeat (stall) begin
                    @(negedge clk_i);
                    if (cline_valid !== 1'b1 || cline_data !== d || cline_last !== exp_last ||
                        rd_req_valid !== 1'b0 || rd_resp_ready !== 1'b0)
                        stable = 1'b0;
                end
                cmpdcmp_trigger = 1'b0;
                total++;
                if (!stable) begin
                    bad++; $display("FAIL %s_stall%0d: line not held or request issued, stable=%0d want 1",
                                    tag, i, stable);
                end
            end
            cline_ready = 1'b1;
            @(negedge clk_i);
            cline_ready = 1'b0;
        end
        if (eff > 0) begin
            total++;
            if (cmpdcmp_done !== 1'b1 || cline_valid !== 1'b0) begin
                bad++; $display("FAIL %s_done: done=%b cline=%b want 1 0", tag, cmpdcmp_done, cline_valid);
            end
        end
        @(negedge clk_i);
        total++;
        if (cmpdcmp_done !== 1'b0 || zspg_valid !== 1'b0 || md_mismatch !== exp_mm || nxtway_ptr !== nxt) begin
            bad++; $display("FAIL %s_idle: done=%b zv=%b mm=%b nxt=%h want 0 0 %b %h",
                            tag, cmpdcmp_done, zspg_valid, md_mismatch, nxtway_ptr, exp_mm, nxt);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        total++;
        if ({rd_req_valid, rd_resp_ready, zspg_valid, cline_valid, cline_last, cmpdcmp_done, md_mismatch} !== 7'b0 ||
            zspg_md !== '0 || nxtway_ptr !== '0 || rd_req_addr !== '0) begin
            bad++; $display("FAIL reset_vals: req=%b rr=%b zv=%b cv=%b done=%b want all 0",
                            rd_req_valid, rd_resp_ready, zspg_valid, cline_valid, cmpdcmp_done);
        end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        total++;
        if (rd_req_valid !== 1'b0 || cmpdcmp_done !== 1'b0) begin
            bad++; $display("FAIL reset_idle: req=%b done=%b want 0 0", rd_req_valid, cmpdcmp_done);
        end
    endtask

    task automatic test_single();
        run_op("single", 48'h1000, 64'h0000_0000_0008_0000, 7'd1, 48'h1000, 0);
    endtask

    task automatic test_multi_unaligned();
        run_op("multi", 48'h2000, 64'h0000_0001_0000_007F, 7'd3, 48'h2000, 0);
    endtask

    task automatic test_back_pressure();
        run_op("bp", 48'h2400, 64'h0000_0000_00A0_0000, 7'd2, 48'h2400, 10);
    endtask

    task automatic test_zero_lines();
        run_op("zero", 48'h2800, 64'h0000_0000_00B0_0000, 7'd0, 48'h2800, 0);
    endtask

    task automatic test_mismatch();
        logic exp_mm;
`ifdef HAWK_RD_MD_CHECK_EN
        exp_mm = 1'b1;
`else
        exp_mm = 1'b0;
`endif
        run_op("mm", 48'h1000, 64'h0000_0000_00C0_0000, 7'd0, 48'h1040, 0);
        repeat (5) @(negedge clk_i);
        total++;
        if (md_mismatch !== exp_mm) begin
            bad++; $display("FAIL mm_hold: md_mismatch=%b want %b", md_mismatch, exp_mm);
        end
        run_op("mm_next", 48'h1000, 64'h0000_0000_00C0_0000, 7'd1, 48'h1000, 0);
    endtask

    task automatic test_addr_wrap();
        run_op("wrap", 48'h3400, 64'hFFFF_FFFF_FFFF_FFC5, 7'd2, 48'h3400, 0);
    endtask

    task automatic test_clamp();
        run_op("clamp", 48'h3800, 64'h0000_0000_0100_0000, 7'd100, 48'h3800, 0);
    endtask

    task automatic test_reset_mid();
        logic [63:0] a, a0;
        bit ok, stable;
        cmpdcmp_trigger = 1'b1;
        iway_ptr = 48'h3000;
        cpage_byte_start = 64'h0000_0000_0000_5000;
        cpage_nlines = 7'd2;
        @(negedge clk_i);
        cmpdcmp_trigger = 1'b0;
        serve_req(a, ok);
        give_resp({16'h0, 48'h3040, 48'h4000, {25{16'h5A5A}}}, ok);
        a0 = rd_req_addr;
        stable = (rd_req_valid === 1'b1);
        repeat (3) begin
            @(negedge clk_i);
            if (rd_req_valid !== 1'b1 || rd_req_addr !== a0) stable = 1'b0;
        end
        total++;
        if (!stable || a0 !== 64'h5000) begin
            bad++; $display("FAIL rst_req_hold: stable=%0d addr=%h want 1 %h", stable, a0, 64'h5000);
        end
        serve_req(a, ok);
        total++;
        if (rd_resp_ready !== 1'b1) begin
            bad++; $display("FAIL rst_cp_resp_rdy: rd_resp_ready=%b want 1", rd_resp_ready);
        end
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if ({rd_req_valid, rd_resp_ready, zspg_valid, cline_valid, cline_last, cmpdcmp_done, md_mismatch} !== 7'b0 ||
            zspg_md !== '0 || nxtway_ptr !== '0 || cline_data !== '0) begin
            bad++; $display("FAIL rst_mid_outs: req=%b rr=%b cv=%b done=%b mm=%b nxt=%h want all 0",
                            rd_req_valid, rd_resp_ready, cline_valid, cmpdcmp_done, md_mismatch, nxtway_ptr);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_op("post_rst", 48'h1000, 64'h0000_0000_0009_0000, 7'd1, 48'h1000, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_unaligned();
        test_back_pressure();
        test_zero_lines();
        test_mismatch();
        test_addr_wrap();
        test_clamp();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
